mask_blinker_multi: RTL and testbench

Multi-channel LED pattern blinker: the parametrised successor to the single 8-bit mask blinker in the HD44780 controller. It holds NUM_CH independent MASK_BITS-wide patterns, loaded over a Wishbone-style strobe/ack port. It steps every channel on a shared prescaled tick, in either looping or one-shot mode. It sits between the controller's command logic (button/DIP-switch or host writes) and the board LEDs, and reports per-channel busy status back to the controller.

---
 rtl/mask_blinker_multi.sv | 78 +++++++
 tb/tb_mask_blinker_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mask_blinker_multi.sv
// Multi-channel LED pattern blinker: NUM_CH loadable shift patterns stepped on a
// shared prescaler tick, each in loop (rotate) or one-shot (shift out) mode.
module mask_blinker_multi #(
  parameter int NUM_CH    = 4,
  parameter int CH_BITS   = 2,
  parameter int MASK_BITS = 8,
  parameter int CLK_BITS  = 7
) (
  input  logic                 i_clk,
  input  logic                 RST_I,
  input  logic                 STB_I,
  input  logic [CH_BITS-1:0]   ADR_I,
  input  logic [MASK_BITS-1:0] DAT_I,
  input  logic                 MODE_I,
  output logic                 ACK_O,
  output logic [NUM_CH-1:0]    o_led,
  output logic [NUM_CH-1:0]    o_busy
);
  localparam int                STEP_W    = $clog2(MASK_BITS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MASK_BITS);

  logic [CLK_BITS-1:0] presc;
  logic                tick;
  logic                load_acc;

  assign tick     = &presc;
  // A strobe seen while the previous ack is still high is the same transfer.
  assign load_acc = STB_I & ~ACK_O;

  always_ff @(posedge i_clk) begin
    if (RST_I) begin
      presc <= '0;
      ACK_O <= 1'b0;
    end else begin
      presc <= presc + CLK_BITS'(1);
      ACK_O <= load_acc;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Out-of-range addresses never match any channel, so they ack with no effect.
    localparam logic [CH_BITS-1:0] CH_ADR = CH_BITS'(g);

    logic [MASK_BITS-1:0] sh;
    logic                 mode;
    logic [STEP_W-1:0]    step;
    logic                 busy;
    logic                 hit;

    assign hit = load_acc && (ADR_I == CH_ADR);

    always_ff @(posedge i_clk) begin
      if (RST_I) begin
        sh   <= '0;
        mode <= 1'b0;
        step <= '0;
        busy <= 1'b0;
      end else if (hit) begin
        sh   <= DAT_I;
        mode <= MODE_I;
        step <= '0;
        busy <= |DAT_I;
      end else if (tick) begin
        if (!mode) begin
          sh <= {sh[MASK_BITS-2:0], sh[MASK_BITS-1]};
        end else if (busy) begin
          sh   <= {sh[MASK_BITS-2:0], 1'b0};
          step <= step + STEP_W'(1);
          busy <= (step + STEP_W'(1)) != STEP_LAST;
        end
      end
    end

    assign o_led[g]  = sh[MASK_BITS-1];
    assign o_busy[g] = busy;
  end

endmodule

// File: tb/tb_mask_blinker_multi.sv
// Bench for mask_blinker_multi: directed vector table, hand-written corner
// sequences and random traffic, all compared against a pattern-level model.
module tb_mask_blinker_multi;
  logic       i_clk = 1'b0;
  logic       RST_I, STB_I, MODE_I;
  logic [1:0] ADR_I;
  logic [7:0] DAT_I;
  logic       ACK_O;
  logic [3:0] o_led, o_busy;
  logic       ack3;
  logic [2:0] led3, busy3;

  always #5 i_clk = ~i_clk;

  mask_blinker_multi #(.NUM_CH(4), .CH_BITS(2), .MASK_BITS(8), .CLK_BITS(3)) dut (
    .i_clk(i_clk), .RST_I(RST_I), .STB_I(STB_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .MODE_I(MODE_I), .ACK_O(ACK_O), .o_led(o_led), .o_busy(o_busy));

  // Three-channel copy on the same bus: address 3 is out of range for it.
  mask_blinker_multi #(.NUM_CH(3), .CH_BITS(2), .MASK_BITS(8), .CLK_BITS(3)) dut3 (
    .i_clk(i_clk), .RST_I(RST_I), .STB_I(STB_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .MODE_I(MODE_I), .ACK_O(ack3), .o_led(led3), .o_busy(busy3));

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Model: per channel the loaded mask, its mode and the ticks seen since load.
  logic [7:0] m_mask [4];
  logic       m_mode [4];
  int         m_n    [4];
  int         m_phase;
  logic       m_ack;

  function automatic logic ref_led(input int ch);
    int n = m_n[ch];
    if (!m_mode[ch]) return m_mask[ch][7 - (n % 8)];
    return (n < 8) ? m_mask[ch][7 - n] : 1'b0;
  endfunction

  function automatic logic ref_busy(input int ch);
    return (m_mask[ch] != 8'h00) && (!m_mode[ch] || m_n[ch] < 8);
  endfunction

  task automatic model_update();
    logic tick_m, acc;
    if (RST_I) begin
      m_phase = 0;
      m_ack   = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        m_mask[ch] = 8'h00; m_mode[ch] = 1'b0; m_n[ch] = 0;
      end
    end else begin
      tick_m  = (m_phase == 7);
      m_phase = (m_phase + 1) % 8;
      acc     = STB_I && !m_ack;
      m_ack   = acc;
      for (int ch = 0; ch < 4; ch++) begin
        if (acc && int'(ADR_I) == ch) begin
          m_mask[ch] = DAT_I; m_mode[ch] = MODE_I; m_n[ch] = 0;
        end else if (tick_m && m_n[ch] < 1000) begin
          m_n[ch]++;
        end
      end
    end
  endtask

  task automatic model_check();
    logic [3:0] el, eb;
    for (int ch = 0; ch < 4; ch++) begin
      el[ch] = ref_led(ch);
      eb[ch] = ref_busy(ch);
    end
    tests++;
    if (ACK_O !== m_ack || o_led !== el || o_busy !== eb) begin
      fails++;
      $display("FAIL model t=%0t ack/led/busy actual=%b/%b/%b required=%b/%b/%b",
               $time, ACK_O, o_led, o_busy, m_ack, el, eb);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [1:0] a,
                     input logic [7:0] d, input logic m);
    RST_I = r; STB_I = s; ADR_I = a; DAT_I = d; MODE_I = m;
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    if (chk_en) model_check();
  endtask

  typedef struct {
    logic       stb;
    logic [1:0] adr;
    logic [7:0] dat;
    logic       mode;
    logic       ack;
    logic [3:0] led;
    logic [3:0] busy;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] p0 = 8'hA0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1);
  end

  initial begin
    // Edges E1..E17 after reset; the prescaler ticks on E8 and E16.
    vt.push_back('{1'b1, 2'd0, 8'hA0, 1'b0, 1'b1, 4'b0001, 4'b0001});
    vt.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001, 4'b0001});
    vt.push_back('{1'b1, 2'd1, 8'h40, 1'b0, 1'b1, 4'b0001, 4'b0011});
    vt.push_back('{1'b1, 2'd1, 8'hFF, 1'b0, 1'b0, 4'b0001, 4'b0011});
    vt.push_back('{1'b1, 2'd1, 8'h80, 1'b0, 1'b1, 4'b0011, 4'b0011});
    vt.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 1'b0, 4'b0011, 4'b0011});
    vt.push_back('{1'b1, 2'd2, 8'hC0, 1'b1, 1'b1, 4'b0111, 4'b0111});
    vt.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0100, 4'b0111});
    for (int i = 0; i < 7; i++)
      vt.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0100, 4'b0111});
    vt.push_back('{1'b1, 2'd3, 8'hFF, 1'b0, 1'b1, 4'b1001, 4'b1111});
    vt.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b1001, 4'b1111});

    cyc(1'b1, 1'b1, 2'd0, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("rst_ack", 32'(ACK_O), 32'(0));
    chk("rst_led", 32'(o_led), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));

    foreach (vt[i]) begin
      cyc(1'b0, vt[i].stb, vt[i].adr, vt[i].dat, vt[i].mode);
      chk("tbl_ack", 32'(ACK_O), 32'(vt[i].ack));
      chk("tbl_led", 32'(o_led), 32'(vt[i].led));
      chk("tbl_busy", 32'(o_busy), 32'(vt[i].busy));
      chk("tbl_ack3", 32'(ack3), 32'(vt[i].ack));
      chk("tbl_led3", 32'(led3), 32'(vt[i].led[2:0]));
      chk("tbl_busy3", 32'(busy3), 32'(vt[i].busy[2:0]));
    end

    // Loop pattern on ch0 per tick, one-shot end on ch2 at the 8th tick (E64).
    for (int e = 18; e <= 64; e++) begin
      cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      if (e % 8 == 0) begin
        chk("loop_led0", 32'(o_led[0]), 32'(p0[7 - ((e / 8) % 8)]));
        chk("loop_busy0", 32'(o_busy[0]), 32'(1));
      end
      if (e == 63) chk("oneshot_busy_pre", 32'(o_busy[2]), 32'(1));
      if (e == 64) begin
        chk("oneshot_busy_end", 32'(o_busy[2]), 32'(0));
        chk("oneshot_led_end", 32'(o_led[2]), 32'(0));
      end
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("oneshot_idle_led", 32'(o_led[2]), 32'(0));
    chk("oneshot_idle_busy", 32'(o_busy[2]), 32'(0));

    // Reset mid-pattern with a simultaneous strobe.
    cyc(1'b0, 1'b1, 2'd2, 8'hF0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 2'd1, 8'hFF, 1'b0);
    chk("midrst_led", 32'(o_led), 32'(0));
    chk("midrst_busy", 32'(o_busy), 32'(0));
    chk("midrst_ack", 32'(ACK_O), 32'(0));
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("postrst_led", 32'(o_led), 32'(0));
    chk("postrst_busy", 32'(o_busy), 32'(0));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r, s, m;
      logic [1:0] a;
      logic [7:0] d;
      r = ($urandom_range(199) == 0);
      s = ($urandom_range(2) == 0);
      a = 2'($urandom);
      d = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      m = 1'($urandom);
      cyc(r, s, a, d, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
